// File: rtl/intan_pkg.sv
// ---------------------------------------------------------------------------
// intan_pkg
// Shared definitions for the intan sequencing controller:
//   - state_t     : controller FSM encoding (4 bits)
//   - hs_phase_t  : phase encoding of one fs/fd handshake
//   - dbg_t       : debug bundle exposing every FSM state
//   - DEV_*       : device kind codes reported after a check
//   - DEFAULT_*   : default timeout and check retry limit
// ---------------------------------------------------------------------------
package intan_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_CHK      = 4'd1,
        ST_CHK_REL  = 4'd2,
        ST_EVAL     = 4'd3,
        ST_CONF     = 4'd4,
        ST_CONF_REL = 4'd5,
        ST_RUN      = 4'd6,
        ST_READ     = 4'd7,
        ST_READ_REL = 4'd8,
        ST_ERR      = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        HS_IDLE = 2'd0,
        HS_HOLD = 2'd1,   // fs high, waiting for fd=1
        HS_REL  = 2'd2    // fs low, waiting for fd=0
    } hs_phase_t;

    typedef struct packed {
        state_t    state;
        hs_phase_t chk_phase;
        hs_phase_t conf_phase;
        hs_phase_t rd_phase;
    } dbg_t;

    localparam logic [1:0] DEV_NONE = 2'b00;
    localparam logic [1:0] DEV_ONE  = 2'b01;
    localparam logic [1:0] DEV_TWO  = 2'b10;
    localparam logic [1:0] DEV_FOUR = 2'b11;

    localparam logic [15:0] DEFAULT_TIMEOUT     = 16'd4096;
    localparam int unsigned DEFAULT_CHECK_RETRY = 3;

endpackage

// File: rtl/fs_handshake.sv
// ---------------------------------------------------------------------------
// fs_handshake
// One fs/fd start/done phase with its own timeout.
// Handshake: on req the strobe go (fs) rises and is held until fd=1 is
// sampled; go then drops and the phase completes once fd=0 is sampled.
// Each of the two waits gets TIMEOUT cycles.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   req       : one-cycle request, accepted only when the phase is idle
//   fd        : done level from intan
//   go        : registered start strobe to intan
//   ack       : fd=1 seen while go is held (combinational)
//   done      : fd=0 seen after go dropped (combinational)
//   tmo       : current wait expired (combinational)
//   phase     : handshake phase, for debug
// ---------------------------------------------------------------------------
module fs_handshake
    import intan_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      req,
    input  logic      fd,
    output logic      go,
    output logic      ack,
    output logic      done,
    output logic      tmo,
    output hs_phase_t phase
);

    logic [15:0] cnt;
    logic        expired;

    assign expired = (cnt == TIMEOUT - 16'd1);
    assign ack     = (phase == HS_HOLD) && fd;
    assign done    = (phase == HS_REL) && !fd;
    // Expiry only matters when the awaited level has not arrived this cycle.
    assign tmo     = expired && (((phase == HS_HOLD) && !fd) ||
                                 ((phase == HS_REL)  &&  fd));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= HS_IDLE;
            go    <= 1'b0;
            cnt   <= 16'd0;
        end else begin
            case (phase)
                HS_IDLE: begin
                    if (req) begin
                        phase <= HS_HOLD;
                        go    <= 1'b1;
                        cnt   <= 16'd0;
                    end
                end
                HS_HOLD: begin
                    if (ack) begin
                        phase <= HS_REL;
                        go    <= 1'b0;
                        cnt   <= 16'd0;
                    end else if (tmo) begin
                        phase <= HS_IDLE;
                        go    <= 1'b0;
                        cnt   <= 16'd0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                HS_REL: begin
                    if (done || tmo) begin
                        phase <= HS_IDLE;
                        cnt   <= 16'd0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    phase <= HS_IDLE;
                    go    <= 1'b0;
                    cnt   <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/intan_ctrl.sv
// ---------------------------------------------------------------------------
// intan_ctrl
// Sequencing controller for the intan acquisition block: check the device,
// configure it, then issue one read per sample tick. Each fs/fd phase runs in
// its own fs_handshake instance; this module owns the sequencing FSM and the
// status counters.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start, stop, tick   : control pulses from the system top level
//   fs_check/fd_check   : check handshake
//   fs_conf/fd_conf     : configure handshake
//   fs_read/fd_read     : read handshake
//   dev_kind_in         : device kind reported by intan after a check
//   dev_kind            : latched device kind
//   ready, busy, err    : status (err is sticky until the next start)
//   read_cnt            : completed reads, wraps
//   overrun             : dropped ticks, saturates at 8'hFF
//   dbg                 : controller and handshake phase states
// ---------------------------------------------------------------------------
module intan_ctrl
    import intan_pkg::*;
#(
    parameter logic [15:0] TIMEOUT     = DEFAULT_TIMEOUT,
    parameter int unsigned CHECK_RETRY = DEFAULT_CHECK_RETRY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        tick,
    output logic        fs_check,
    input  logic        fd_check,
    output logic        fs_conf,
    input  logic        fd_conf,
    output logic        fs_read,
    input  logic        fd_read,
    input  logic [1:0]  dev_kind_in,
    output logic [1:0]  dev_kind,
    output logic        ready,
    output logic        busy,
    output logic        err,
    output logic [15:0] read_cnt,
    output logic [7:0]  overrun,
    output dbg_t        dbg
);

    localparam logic [7:0] RETRY_LIMIT = 8'(CHECK_RETRY);

    state_t     state, state_nxt;
    logic [7:0] retry;
    logic       pend, stop_pend;
    logic       chk_req, chk_ack, chk_done, chk_tmo;
    logic       conf_req, conf_ack, conf_done, conf_tmo;
    logic       rd_req, rd_ack, rd_done, rd_tmo;
    hs_phase_t  chk_phase, conf_phase, rd_phase;
    logic       in_read;

    assign in_read = (state == ST_READ) || (state == ST_READ_REL);

    // Handshake requests are derived from the next state so fs rises on the
    // same edge that the controller enters the phase.
    assign chk_req  = (state_nxt == ST_CHK)  && (state != ST_CHK);
    assign conf_req = (state_nxt == ST_CONF) && (state != ST_CONF);
    assign rd_req   = (state_nxt == ST_READ) && (state != ST_READ);

    fs_handshake #(.TIMEOUT(TIMEOUT)) u_chk (
        .clk(clk), .rst(rst), .req(chk_req), .fd(fd_check),
        .go(fs_check), .ack(chk_ack), .done(chk_done), .tmo(chk_tmo),
        .phase(chk_phase)
    );

    fs_handshake #(.TIMEOUT(TIMEOUT)) u_conf (
        .clk(clk), .rst(rst), .req(conf_req), .fd(fd_conf),
        .go(fs_conf), .ack(conf_ack), .done(conf_done), .tmo(conf_tmo),
        .phase(conf_phase)
    );

    fs_handshake #(.TIMEOUT(TIMEOUT)) u_rd (
        .clk(clk), .rst(rst), .req(rd_req), .fd(fd_read),
        .go(fs_read), .ack(rd_ack), .done(rd_done), .tmo(rd_tmo),
        .phase(rd_phase)
    );

    assign dbg = {state, chk_phase, conf_phase, rd_phase};

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (start) state_nxt = ST_CHK;
            ST_CHK:      if (chk_ack) state_nxt = ST_CHK_REL;
                         else if (chk_tmo) state_nxt = ST_ERR;
            ST_CHK_REL:  if (chk_done) state_nxt = ST_EVAL;
                         else if (chk_tmo) state_nxt = ST_ERR;
            ST_EVAL: begin
                if (dev_kind_in != DEV_NONE)            state_nxt = ST_CONF;
                else if (retry + 8'd1 >= RETRY_LIMIT)   state_nxt = ST_ERR;
                else                                    state_nxt = ST_CHK;
            end
            ST_CONF:     if (conf_ack) state_nxt = ST_CONF_REL;
                         else if (conf_tmo) state_nxt = ST_ERR;
            ST_CONF_REL: if (conf_done) state_nxt = ST_RUN;
                         else if (conf_tmo) state_nxt = ST_ERR;
            // stop has priority over a tick in the same cycle
            ST_RUN:      if (stop) state_nxt = ST_IDLE;
                         else if (tick || pend) state_nxt = ST_READ;
            ST_READ:     if (rd_ack) state_nxt = ST_READ_REL;
                         else if (rd_tmo) state_nxt = ST_ERR;
            ST_READ_REL: if (rd_done) state_nxt = (stop_pend || stop) ? ST_IDLE : ST_RUN;
                         else if (rd_tmo) state_nxt = ST_ERR;
            ST_ERR:      if (start) state_nxt = ST_CHK;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            dev_kind  <= DEV_NONE;
            ready     <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            read_cnt  <= 16'd0;
            overrun   <= 8'd0;
            retry     <= 8'd0;
            pend      <= 1'b0;
            stop_pend <= 1'b0;
        end else begin
            state <= state_nxt;
            ready <= (state_nxt == ST_RUN) || (state_nxt == ST_READ) ||
                     (state_nxt == ST_READ_REL);
            busy  <= !(state_nxt inside {ST_IDLE, ST_RUN, ST_ERR});
            err   <= (state_nxt == ST_ERR);

            // A fresh sequence forgets the old kind; a retry keeps it.
            if ((state == ST_IDLE || state == ST_ERR) && state_nxt == ST_CHK) begin
                dev_kind <= DEV_NONE;
                retry    <= 8'd0;
            end else if (state == ST_EVAL) begin
                if (dev_kind_in != DEV_NONE) begin
                    dev_kind <= dev_kind_in;
                    retry    <= 8'd0;
                end else begin
                    retry <= retry + 8'd1;
                end
            end

            if (state == ST_READ_REL && rd_done)
                read_cnt <= read_cnt + 16'd1;

            // One tick can wait behind an active read; further ones are dropped.
            if (in_read && tick && pend && overrun != 8'hFF)
                overrun <= overrun + 8'd1;

            if (state_nxt == ST_IDLE || state_nxt == ST_ERR)
                pend <= 1'b0;
            else if (state == ST_RUN)
                pend <= 1'b0;
            else if (in_read && tick)
                pend <= 1'b1;

            if (state_nxt != ST_READ && state_nxt != ST_READ_REL)
                stop_pend <= 1'b0;
            else if (stop)
                stop_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_intan_ctrl.sv
module tb_intan_ctrl;
    import intan_pkg::*;

    localparam logic [15:0] TMO = 16'd64;

    logic        clk, rst, start, stop, tick;
    logic        fs_check, fd_check, fs_conf, fd_conf, fs_read, fd_read;
    logic [1:0]  dev_kind_in, dev_kind;
    logic        ready, busy, err;
    logic [15:0] read_cnt;
    logic [7:0]  overrun;
    dbg_t        dbg;

    int n_checks = 0;
    int n_pass   = 0;

    // responder configuration
    int         chk_dly  = 5;
    int         conf_dly = 3;
    int         rd_dly   = 4;
    bit         conf_en  = 1'b1;
    logic [1:0] chk_kind = 2'b01;

    // strobe rising-edge monitors
    int   chk_rise = 0;
    int   rd_rise  = 0;
    logic chk_q    = 1'b0;
    logic rd_q     = 1'b0;

    logic [15:0] exp_rd;

    typedef struct {
        logic [1:0] kind;
        logic [1:0] exp_dk;
        logic       exp_err;
        logic       exp_ready;
        int         exp_pulses;
    } vec_t;
    vec_t vecs[5];

    intan_ctrl #(.TIMEOUT(TMO), .CHECK_RETRY(3)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .tick(tick),
        .fs_check(fs_check), .fd_check(fd_check),
        .fs_conf(fs_conf), .fd_conf(fd_conf),
        .fs_read(fs_read), .fd_read(fd_read),
        .dev_kind_in(dev_kind_in), .dev_kind(dev_kind),
        .ready(ready), .busy(busy), .err(err),
        .read_cnt(read_cnt), .overrun(overrun), .dbg(dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks so far %0d", n_checks);
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog expired");
    end

    assign dev_kind_in = chk_kind;

    always @(negedge clk) begin
        if (fs_check && !chk_q) chk_rise++;
        if (fs_read && !rd_q) rd_rise++;
        chk_q = fs_check;
        rd_q  = fs_read;
    end

    // ---------------- intan responders ----------------
    initial begin
        fd_check = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (fs_check && !fd_check) begin
                repeat (chk_dly) @(posedge clk);
                #1 fd_check = 1'b1;
                while (fs_check) begin @(posedge clk); #1; end
                fd_check = 1'b0;
            end
        end
    end

    initial begin
        fd_conf = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (fs_conf && !fd_conf && conf_en) begin
                repeat (conf_dly) @(posedge clk);
                #1 fd_conf = 1'b1;
                while (fs_conf) begin @(posedge clk); #1; end
                fd_conf = 1'b0;
            end
        end
    end

    initial begin
        fd_read = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (fs_read && !fd_read) begin
                repeat (rd_dly) @(posedge clk);
                #1 fd_read = 1'b1;
                while (fs_read) begin @(posedge clk); #1; end
                fd_read = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(1); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; cyc(1); stop = 1'b0;
    endtask

    task automatic pulse_tick();
        tick = 1'b1; cyc(1); tick = 1'b0;
    endtask

    task automatic wait_settled(input string name);
        int i;
        i = 0;
        while (!(ready || err) && i < 2000) begin cyc(1); i++; end
        check(name, 32'(ready || err), 32'd1);
    endtask

    // wait until the controller stays non-busy for 3 cycles in a row
    task automatic wait_quiet(input string name);
        int i, q;
        i = 0; q = 0;
        while (q < 3 && i < 1000) begin
            cyc(1); i++;
            q = busy ? 0 : q + 1;
        end
        check(name, 32'(q >= 3), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base, i;
        vecs[0] = '{2'b01, 2'b01, 1'b0, 1'b1, 1};
        vecs[1] = '{2'b10, 2'b10, 1'b0, 1'b1, 1};
        vecs[2] = '{2'b00, 2'b00, 1'b1, 1'b0, 3};
        vecs[3] = '{2'b11, 2'b11, 1'b0, 1'b1, 1};
        vecs[4] = '{2'b01, 2'b01, 1'b0, 1'b1, 1};

        rst = 1'b1; start = 1'b0; stop = 1'b0; tick = 1'b0;
        exp_rd = 16'd0;
        cyc(3);
        check("rst_fs", {29'd0, fs_check, fs_conf, fs_read}, 32'd0);
        check("rst_status", {28'd0, ready, busy, err, 1'b0}, 32'd0);
        check("rst_counts", {8'd0, read_cnt, overrun}, 32'd0);
        check("rst_dev_kind", 32'(dev_kind), 32'd0);
        rst = 1'b0;
        cyc(2);
        check("idle_state", 32'(dbg.state), 32'(ST_IDLE));
        check("idle_fs", {29'd0, fs_check, fs_conf, fs_read}, 32'd0);

        // ---- table: check/conf bring-up per device kind ----
        for (int v = 0; v < 5; v++) begin
            if (v > 0 && vecs[v-1].exp_ready) begin
                pulse_stop();
                check("stop_to_idle", 32'(ready), 32'd0);
            end
            chk_kind = vecs[v].kind;
            base = chk_rise;
            check("fs_check_before_start", 32'(fs_check), 32'd0);
            pulse_start();
            check("fs_check_next_cycle", 32'(fs_check), 32'd1);
            check("dev_kind_cleared", 32'(dev_kind), 32'd0);
            check("err_cleared_on_start", 32'(err), 32'd0);
            wait_settled("settle_bounded");
            cyc(2);
            check("vec_dev_kind", 32'(dev_kind), 32'(vecs[v].exp_dk));
            check("vec_err", 32'(err), 32'(vecs[v].exp_err));
            check("vec_ready", 32'(ready), 32'(vecs[v].exp_ready));
            check("vec_busy", 32'(busy), 32'd0);
            check("vec_check_pulses", 32'(chk_rise - base), 32'(vecs[v].exp_pulses));
        end

        // ---- periodic reads, fast responder ----
        rd_dly = 4;
        base = rd_rise;
        for (int k = 0; k < 10; k++) begin
            pulse_tick();
            cyc(19);
        end
        exp_rd = exp_rd + 16'd10;
        check("reads10_read_cnt", 32'(read_cnt), 32'(exp_rd));
        check("reads10_pulses", 32'(rd_rise - base), 32'd10);
        check("reads10_overrun", 32'(overrun), 32'd0);

        // ---- slow responder: one pending read, extra ticks overrun ----
        rd_dly = 50;
        base = rd_rise;
        for (int k = 0; k < 5; k++) begin
            pulse_tick();
            cyc(9);
        end
        i = 0;
        while (read_cnt == exp_rd && i < 200) begin cyc(1); i++; end
        check("slow_first_done", 32'(read_cnt), 32'(exp_rd + 16'd1));
        cyc(1);
        check("pending_read_back_to_back", 32'(fs_read), 32'd1);
        wait_quiet("slow_quiet");
        exp_rd = exp_rd + 16'd2;
        check("slow_read_cnt", 32'(read_cnt), 32'(exp_rd));
        check("slow_pulses", 32'(rd_rise - base), 32'd2);
        check("slow_overrun", 32'(overrun), 32'd3);

        // ---- 300-tick burst saturates overrun ----
        base = rd_rise;
        tick = 1'b1;
        cyc(300);
        tick = 1'b0;
        check("burst_overrun_sat", 32'(overrun), 32'hFF);
        wait_quiet("burst_quiet");
        exp_rd = exp_rd + 16'(rd_rise - base);
        check("burst_read_cnt", 32'(read_cnt), 32'(exp_rd));
        check("burst_overrun_held", 32'(overrun), 32'hFF);

        // ---- conf never answers: timeout to ERR ----
        pulse_stop();
        conf_en = 1'b0;
        pulse_start();
        i = 0;
        while (!fs_conf && i < 200) begin cyc(1); i++; end
        check("conf_rise", 32'(fs_conf), 32'd1);
        cyc(int'(TMO) - 1);
        check("conf_held_before_tmo", {30'd0, fs_conf, err}, 32'b10);
        cyc(1);
        check("conf_tmo_err", {30'd0, fs_conf, err}, 32'b01);
        check("conf_tmo_status", {30'd0, ready, busy}, 32'd0);
        base = rd_rise;
        stop = 1'b1; tick = 1'b1;
        cyc(1);
        stop = 1'b0; tick = 1'b0;
        cyc(3);
        check("err_ignores_stop_tick", {29'd0, err, ready, fs_read}, 32'b100);
        check("err_no_read", 32'(rd_rise - base), 32'd0);
        check("err_holds_counts", {8'd0, read_cnt, overrun}, {8'd0, exp_rd, 8'hFF});
        check("err_holds_dev_kind", 32'(dev_kind), 32'(2'b01));
        conf_en = 1'b1;
        pulse_start();
        wait_settled("recover_bounded");
        check("recover_ready", {30'd0, ready, err}, 32'b10);

        // ---- stop and tick in the same RUN cycle ----
        base = rd_rise;
        stop = 1'b1; tick = 1'b1;
        cyc(1);
        stop = 1'b0; tick = 1'b0;
        check("stop_tick_idle", {30'd0, ready, fs_read}, 32'd0);
        cyc(5);
        check("stop_tick_no_read", 32'(rd_rise - base), 32'd0);
        check("stop_tick_read_cnt", 32'(read_cnt), 32'(exp_rd));

        // ---- stop during READ: read completes first ----
        pulse_start();
        wait_settled("restart_bounded");
        rd_dly = 10;
        base = rd_rise;
        pulse_tick();
        check("read_started", 32'(fs_read), 32'd1);
        cyc(2);
        pulse_stop();
        check("stop_in_read_still_ready", 32'(ready), 32'd1);
        i = 0;
        while (ready && i < 200) begin cyc(1); i++; end
        exp_rd = exp_rd + 16'd1;
        check("stop_in_read_cnt", 32'(read_cnt), 32'(exp_rd));
        cyc(3);
        check("stop_in_read_idle", {29'd0, ready, busy, err}, 32'd0);
        check("stop_in_read_pulses", 32'(rd_rise - base), 32'd1);

        // ---- reset in the middle of a read ----
        pulse_start();
        wait_settled("restart2_bounded");
        pulse_tick();
        cyc(3);
        check("mid_read_fs", 32'(fs_read), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_fs", {29'd0, fs_check, fs_conf, fs_read}, 32'd0);
        check("async_rst_status", {28'd0, ready, busy, err, 1'b0}, 32'd0);
        check("async_rst_counts", {8'd0, read_cnt, overrun}, 32'd0);
        check("async_rst_dev_kind", 32'(dev_kind), 32'd0);
        cyc(2);
        rst = 1'b0;
        cyc(70);
        check("after_rst_idle", 32'(dbg.state), 32'(ST_IDLE));
        check("after_rst_fs", {29'd0, fs_check, fs_conf, fs_read}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
